vote_logic_pipe: RTL
====================

# vote_logic_pipe

Parametrised, pipelined successor to the team's 3-input majority/OR combinational block. It accepts a beat of N_CH independent channels, each N_IN bits wide, over a valid/ready handshake and computes two results per channel: a mode-selectable vote (majority, all, any or threshold) and an always-present OR. Results are registered with a 2-entry skid buffer so the block can sit between streaming stages without a combinational ready path. An optional saturating counter tracks channel disagreement for health monitoring.

## Interface
- N_IN, 3, inputs per channel; odd, 3..15
- N_CH, 4, channel count; 1..32
- CNT_W, 16, disagreement counter width
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  beat valid
- in_ready  output  1  block can accept a beat; registered
- in_bits  input  N_CH*N_IN  channel c occupies bits [c*N_IN +: N_IN]
- mode  input  2  00 majority, 01 any (OR), 10 all (AND), 11 threshold; sampled with beat
- thresh  input  $clog2(N_IN+1)  threshold for mode 11; sampled with beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_vote  output  N_CH  per-channel vote per sampled mode
- out_any  output  N_CH  per-channel OR, independent of mode
- clear_cnt  input  1  synchronous clear of disagree_cnt
- disagree_cnt  output  CNT_W  saturating disagreement count

## Operation
- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- Per channel: pc = popcount(bits). Majority: pc > N_IN/2. Any: pc != 0. All: pc == N_IN. Threshold: pc >= thresh; thresh=0 gives 1; thresh > N_IN gives 0.
- out_any = (pc != 0) always.
- Storage: output register (OUT) plus one skid register (SKID). Accepted beat goes to OUT if OUT empty or draining this cycle, else to SKID.
- in_ready next = SKID empty after this cycle's updates. When OUT drains and SKID full, SKID moves to OUT same edge; in_ready rises the following cycle.
- Order strictly preserved; no beat dropped or duplicated.
- Outputs held stable while out_valid && !out_ready.
- Disagreement: a channel disagrees on an accepted beat when 0 < pc < N_IN. Counter adds the number of disagreeing channels at accept, saturating at 2^CNT_W-1.
- clear_cnt and increment in the same cycle: clear wins, counter = 0.

## Timing
- Reset values: in_ready 0, out_valid 0, out_vote 0, out_any 0, disagree_cnt 0, SKID empty. in_ready goes 1 the first cycle after reset deasserts.
- Latency: accept at edge t -> out_valid high after edge t (visible cycle t+1).
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure: out_ready low with a beat in OUT -> at most one more beat accepted (into SKID), then in_ready 0.
- Reset mid-operation: OUT and SKID contents discarded, all outputs to reset values next edge.
- disagree_cnt updates on the edge of acceptance, visible the next cycle.

## Configuration
- VOTE_LOGIC_STATS_EN defined: disagreement counter and clear_cnt function as above.
- Not defined: no counter logic; disagree_cnt tied to 0, clear_cnt ignored.

## Structure
- Package vote_logic_pkg: vote_mode_e enum (MAJ, ANY, ALL, THR), popcount function, mode encoding constants.
- Sub-module vote_logic_chan: combinational per-channel popcount, vote and any decision; instantiated N_CH times. Top holds handshake, OUT/SKID registers and counter.

## Test plan
- Defaults, mode 00, in_bits per channel {3'b011,3'b100,3'b111,3'b000}, out_ready 1 -> next cycle out_vote=4'b0101 (ch0 LSB), out_any=4'b0111, disagree_cnt=2.
- Mode 11, channel bits 3'b011: thresh 0 -> vote 1; thresh 2 -> 1; thresh 3 -> 0 (with N_IN=3 thresh max 3; N_IN=5, thresh 6 -> 0).
- out_ready 0, stream 3 beats -> 2 accepted, in_ready 0 from third cycle; release out_ready -> beats emerge in order, in_ready 1 one cycle after SKID empties.
- CNT_W=4, 16 beats each with 1 disagreeing channel -> counter 15 and holds; clear_cnt with concurrent disagreeing beat -> 0.
- Reset asserted with OUT and SKID full -> out_valid 0, in_ready 0 next cycle, in_ready 1 cycle after reset drops, no stale beat emitted.
- Build without VOTE_LOGIC_STATS_EN -> disagree_cnt constant 0 across all above.

Source files
------------

// File: rtl/vote_logic_pkg.sv
// Purpose: shared vote-mode encoding and popcount helper for vote_logic_pipe.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package vote_logic_pkg;

    localparam logic [1:0] MODE_MAJ = 2'b00;
    localparam logic [1:0] MODE_ANY = 2'b01;
    localparam logic [1:0] MODE_ALL = 2'b10;
    localparam logic [1:0] MODE_THR = 2'b11;

    typedef enum logic [1:0] {
        MAJ = MODE_MAJ,
        ANY = MODE_ANY,
        ALL = MODE_ALL,
        THR = MODE_THR
    } vote_mode_e;

    // Widest supported channel; narrower channels are zero-extended by the caller.
    localparam int POP_MAX_W = 15;

    function automatic logic [3:0] popcount(input logic [POP_MAX_W-1:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {3'b000, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_logic_chan.sv
// Purpose: per-channel popcount, mode-selected vote, OR and disagreement flag.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the parent decides when to capture.
// Ports: bits_i (channel inputs), mode_i, thresh_i -> vote_o, any_o,
//        dis_o (inputs neither all-0 nor all-1).
module vote_logic_chan
    import vote_logic_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0]            bits_i,
    input  vote_mode_e                 mode_i,
    input  logic [$clog2(N_IN+1)-1:0]  thresh_i,
    output logic                       vote_o,
    output logic                       any_o,
    output logic                       dis_o
);

    logic [3:0] pc;
    logic [3:0] th;

    assign pc = popcount(POP_MAX_W'(bits_i));
    // Threshold above N_IN naturally yields 0 since pc never exceeds N_IN.
    assign th = 4'(thresh_i);

    always_comb begin
        vote_o = 1'b0;
        case (mode_i)
            MAJ:     vote_o = (pc > 4'(N_IN / 2));
            ANY:     vote_o = (pc != 4'd0);
            ALL:     vote_o = (pc == 4'(N_IN));
            default: vote_o = (pc >= th);
        endcase
    end

    assign any_o = (pc != 4'd0);
    assign dis_o = (pc != 4'd0) && (pc != 4'(N_IN));

endmodule

// File: rtl/vote_logic_pipe.sv
// Purpose: pipelined per-channel vote/OR over a valid/ready stream, optional disagreement stats.
// Latency: 1 cycle accept-to-out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: 2-entry OUT+SKID buffer, in_ready registered; one extra beat absorbed on stall.
// Ports: clk_i, reset_i (sync, active-high); in_valid_i/in_ready_o/in_bits_i/mode_i/thresh_i
//        input beat; out_valid_o/out_ready_i/out_vote_o/out_any_o result; clear_cnt_i and
//        disagree_cnt_o stats, active only when VOTE_LOGIC_STATS_EN is defined.
module vote_logic_pipe
    import vote_logic_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [N_CH*N_IN-1:0]       in_bits_i,
    input  logic [1:0]                 mode_i,
    input  logic [$clog2(N_IN+1)-1:0]  thresh_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N_CH-1:0]            out_vote_o,
    output logic [N_CH-1:0]            out_any_o,
    input  logic                       clear_cnt_i,
    output logic [CNT_W-1:0]           disagree_cnt_o
);

    logic [N_CH-1:0] vote_c, any_c, dis_c;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        vote_logic_chan #(.N_IN(N_IN)) u_chan (
            .bits_i   (in_bits_i[c*N_IN +: N_IN]),
            .mode_i   (vote_mode_e'(mode_i)),
            .thresh_i (thresh_i),
            .vote_o   (vote_c[c]),
            .any_o    (any_c[c]),
            .dis_o    (dis_c[c])
        );
    end

    logic            in_ready_q,   in_ready_d;
    logic            out_valid_q,  out_valid_d;
    logic [N_CH-1:0] out_vote_q,   out_vote_d;
    logic [N_CH-1:0] out_any_q,    out_any_d;
    logic            skid_valid_q, skid_valid_d;
    logic [N_CH-1:0] skid_vote_q,  skid_vote_d;
    logic [N_CH-1:0] skid_any_q,   skid_any_d;

    logic accept;
    logic out_free;

    assign accept   = in_valid_i && in_ready_q;
    assign out_free = !out_valid_q || out_ready_i;

    // in_ready_q mirrors "SKID empty", so an accept never coincides with a full SKID.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_vote_d   = out_vote_q;
        out_any_d    = out_any_q;
        skid_valid_d = skid_valid_q;
        skid_vote_d  = skid_vote_q;
        skid_any_d   = skid_any_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_vote_d   = skid_vote_q;
                out_any_d    = skid_any_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_vote_d  = vote_c;
                out_any_d   = any_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_vote_d  = vote_c;
            skid_any_d   = any_c;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_vote_q   <= '0;
            out_any_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_vote_q  <= '0;
            skid_any_q   <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_vote_q   <= out_vote_d;
            out_any_q    <= out_any_d;
            skid_valid_q <= skid_valid_d;
            skid_vote_q  <= skid_vote_d;
            skid_any_q   <= skid_any_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_vote_o  = out_vote_q;
    assign out_any_o   = out_any_q;

`ifdef VOTE_LOGIC_STATS_EN
    localparam int DW = $clog2(N_CH + 1);
    localparam int SW = CNT_W + DW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    ndis;
    logic [SW-1:0]    sum;

    always_comb begin
        ndis = '0;
        for (int c = 0; c < N_CH; c++) begin
            ndis = ndis + DW'(dis_c[c]);
        end
    end

    // Sum carries DW extra bits so overflow is detected before saturating.
    assign sum = SW'(cnt_q) + SW'(ndis);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign disagree_cnt_o = cnt_q;
`else
    logic unused_stats;
    assign unused_stats   = clear_cnt_i ^ (^dis_c);
    assign disagree_cnt_o = '0;
`endif

endmodule
